// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the single-command SDRAM controller.
// Define SDRAM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module sdram_arbiter #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_sel,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_sel,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              ctrl_in_valid,
    output logic              ctrl_rw,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [3:0]        ctrl_sel,
    output logic [DATA_W-1:0] ctrl_wdata,
    input  logic              ctrl_busy,
    input  logic              ctrl_out_valid,
    input  logic [DATA_W-1:0] ctrl_rdata,
    output logic              grant_id
);

    // state   | meaning
    // IDLE    | no command; arbitrate among requests each edge
    // ISSUE   | command presented to controller until accepted (busy=0)
    // WAIT_RD | read accepted, waiting for out_valid strobe
    // DONE    | one-cycle ack to granted port; requests not sampled
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    state_t            state;
    logic              gnt;
    logic              last;
    logic [DATA_W-1:0] rdata_q;
    logic              issue_q;
    logic [1:0]        ack_q;
    logic              pick;

    always_comb begin
`ifdef SDRAM_ARB_RR_EN
        pick = (m0_req && m1_req) ? ~last : ~m0_req;
`else
        pick = ~m0_req;
`endif
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state   <= IDLE;
            gnt     <= 1'b0;
            last    <= 1'b1;
            rdata_q <= '0;
            issue_q <= 1'b0;
            ack_q   <= 2'b00;
        end else begin
            ack_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt     <= pick;
                        last    <= pick;
                        issue_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!ctrl_busy) begin
                        issue_q <= 1'b0;
                        if (ctrl_rw) begin
                            ack_q[gnt] <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (ctrl_out_valid) begin
                        rdata_q    <= ctrl_rdata;
                        ack_q[gnt] <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    issue_q <= 1'b0;
                end
            endcase
        end
    end

    // Command fields always follow the current/last grant; only in_valid qualifies them.
    assign ctrl_in_valid = issue_q;
    assign ctrl_rw       = gnt ? m1_we    : m0_we;
    assign ctrl_addr     = gnt ? m1_addr  : m0_addr;
    assign ctrl_sel      = gnt ? m1_sel   : m0_sel;
    assign ctrl_wdata    = gnt ? m1_wdata : m0_wdata;

    assign m0_ack   = ack_q[0];
    assign m1_ack   = ack_q[1];
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;
    assign grant_id = gnt;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized checks of sdram_arbiter against a transaction-level model
// with a simple memory-backed controller responder.
module tb_sdram_arbiter;
    localparam int AW = 23;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req, we;
    logic [AW-1:0] addr [2];
    logic [3:0]    sel  [2];
    logic [DW-1:0] wd   [2];
    logic          busy, ov;
    logic [DW-1:0] crd;
    logic          ack0, ack1, iv, crw, gid;
    logic [DW-1:0] rd0, rd1, cwd;
    logic [AW-1:0] cad;
    logic [3:0]    csel;

    always #5 clk = ~clk;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_sel(sel[0]), .m0_wdata(wd[0]),
        .m0_ack(ack0), .m0_rdata(rd0),
        .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_sel(sel[1]), .m1_wdata(wd[1]),
        .m1_ack(ack1), .m1_rdata(rd1),
        .ctrl_in_valid(iv), .ctrl_rw(crw), .ctrl_addr(cad), .ctrl_sel(csel), .ctrl_wdata(cwd),
        .ctrl_busy(busy), .ctrl_out_valid(ov), .ctrl_rdata(crd), .grant_id(gid)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [DW-1:0] mem [int];
    int            last_m, cur_w, ov_cnt, nacks;
    logic [DW-1:0] rdq_m, pend_data;
    bit            pend_rd;
    int            gap [2];
    int            issued [2];
    int            wlog [$];
    logic [1:0]    p_req;
    logic          p_iv, p_busy, p_ov;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] memrd(input int a);
        return mem.exists(a) ? mem[a] : '0;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00; we = 2'b00; busy = 1'b0; ov = 1'b0; crd = '0;
        for (int p = 0; p < 2; p++) begin
            addr[p] = '0; sel[p] = '0; wd[p] = '0;
        end
        tick();
        tick();
        check("rst_in_valid", iv, 0);
        check("rst_acks", {ack0, ack1}, 0);
        check("rst_grant_id", gid, 0);
        check("rst_rdata", rd0, 0);
        rst = 1'b0;
        last_m = 1; cur_w = 0; rdq_m = '0; pend_rd = 0; ov_cnt = 0;
    endtask

    // One clock of the randomized environment: update model from the edge, check, drive.
    task automatic step(input int busy_pct, input int gap_max, input int lim0, input int lim1,
                        input bit spur, input bit wr_only);
        logic [1:0]    ea;
        logic [DW-1:0] m;
        int            w;
        int            lim [2];
        lim[0] = lim0; lim[1] = lim1;
        p_req = req; p_iv = iv; p_busy = busy; p_ov = ov;
        tick();
        ea = 2'b00;
        if (pend_rd && p_ov) begin
            rdq_m = pend_data;
            ea[cur_w] = 1'b1;
            pend_rd = 0;
        end
        if (p_iv && !p_busy) begin
            if (we[cur_w]) begin
                m = memrd(int'(addr[cur_w]));
                for (int b = 0; b < 4; b++)
                    if (sel[cur_w][b]) m[8*b +: 8] = wd[cur_w][8*b +: 8];
                mem[int'(addr[cur_w])] = m;
                ea[cur_w] = 1'b1;
            end else begin
                pend_rd = 1;
                pend_data = memrd(int'(addr[cur_w]));
                ov_cnt = $urandom_range(0, 4);
            end
        end
        if (iv && !p_iv) begin
            check("issue_with_req", (p_req != 2'b00), 1);
`ifdef SDRAM_ARB_RR_EN
            w = (p_req == 2'b11) ? 1 - last_m : (p_req[1] ? 1 : 0);
`else
            w = p_req[0] ? 0 : 1;
`endif
            cur_w = w; last_m = w;
            wlog.push_back(w);
        end
        check("ack0", ack0, ea[0]);
        check("ack1", ack1, ea[1]);
        check("rdata0", rd0, rdq_m);
        check("rdata1", rd1, rdq_m);
        check("grant_id", gid, cur_w[0]);
        if (iv) begin
            check("ctrl_addr", cad, addr[cur_w]);
            check("ctrl_rw", crw, we[cur_w]);
            check("ctrl_sel", csel, sel[cur_w]);
            check("ctrl_wdata", cwd, wd[cur_w]);
        end
        nacks += int'(ea[0]) + int'(ea[1]);
        for (int p = 0; p < 2; p++) begin
            if (ea[p]) begin
                req[p] = 1'b0;
                gap[p] = $urandom_range(0, gap_max);
            end else if (!req[p] && issued[p] < lim[p]) begin
                if (gap[p] > 0) gap[p]--;
                else begin
                    req[p]  = 1'b1;
                    we[p]   = wr_only ? 1'b1 : 1'($urandom_range(0, 1));
                    addr[p] = AW'($urandom_range(0, 15));
                    sel[p]  = 4'($urandom_range(1, 15));
                    wd[p]   = $urandom;
                    issued[p]++;
                end
            end
        end
        busy = ($urandom_range(0, 99) < busy_pct);
        ov   = 1'b0;
        crd  = $urandom;
        if (pend_rd) begin
            if (ov_cnt == 0) begin
                ov  = 1'b1;
                crd = pend_data;
            end else ov_cnt--;
        end else if (spur && $urandom_range(0, 7) == 0) ov = 1'b1;
    endtask

    task automatic run_phase(input int busy_pct, input int gap_max, input int lim0, input int lim1,
                             input bit spur, input bit wr_only);
        int cyc = 0;
        issued[0] = 0; issued[1] = 0; gap[0] = 0; gap[1] = 0;
        nacks = 0;
        wlog.delete();
        while ((nacks < lim0 + lim1 || req != 2'b00 || pend_rd) && cyc < 4000) begin
            step(busy_pct, gap_max, lim0, lim1, spur, wr_only);
            cyc++;
        end
        check("phase_acks", nacks, lim0 + lim1);
    endtask

    initial begin
        do_reset();

        // m0 write with spurious out_valid in IDLE and in ISSUE
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h000010; sel[0] = 4'hF; wd[0] = 32'hDEADBEEF;
        ov = 1'b1; crd = 32'hBAD0BAD0;
        tick();
        check("t1_in_valid", iv, 1);
        check("t1_addr", cad, 23'h000010);
        check("t1_wdata", cwd, 32'hDEADBEEF);
        check("t1_sel", csel, 4'hF);
        check("t1_rw", crw, 1);
        check("t1_grant_id", gid, 0);
        check("t1_no_early_ack", {ack0, ack1}, 0);
        ov = 1'b1; crd = 32'hCAFEF00D; busy = 1'b0;
        tick();
        check("t1_ack0", ack0, 1);
        check("t1_ack1", ack1, 0);
        check("t1_in_valid_off", iv, 0);
        check("t1_rdata_unchanged", rd0, 0);
        req[0] = 1'b0; ov = 1'b0;
        tick();
        check("t1_single_ack", {ack0, ack1}, 0);
        check("t1_in_valid_idle", iv, 0);

        // m1 read, busy for 3 cycles, out_valid in the 5th wait cycle
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 23'h7FFFFF; sel[1] = 4'hF; wd[1] = '0; busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t2_in_valid_held", iv, 1);
            check("t2_addr", cad, 23'h7FFFFF);
            check("t2_rw", crw, 0);
            check("t2_grant_id", gid, 1);
            busy = (k < 4);
        end
        for (int k = 5; k <= 9; k++) begin
            tick();
            check("t2_wait_in_valid", iv, 0);
            check("t2_wait_no_ack", {ack0, ack1}, 0);
            ov  = (k == 9);
            crd = (k == 9) ? 32'h12345678 : 32'h0BADF00D;
        end
        tick();
        check("t2_ack1", ack1, 1);
        check("t2_ack0", ack0, 0);
        check("t2_rdata", rd1, 32'h12345678);
        ov = 1'b0; req[1] = 1'b0;
        tick();
        check("t2_single_ack", ack1, 0);
        check("t2_rdata_hold", rd1, 32'h12345678);

        // reset while waiting for read data, then stale out_valid
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 23'h5;
        tick();
        check("t3_issue", iv, 1);
        tick();
        check("t3_wait", iv, 0);
        rst = 1'b1;
        #1;
        check("t3_rst_in_valid", iv, 0);
        check("t3_rst_acks", {ack0, ack1}, 0);
        check("t3_rst_grant", gid, 0);
        req[1] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        ov = 1'b1; crd = 32'h5A5A5A5A;
        tick();
        check("t3_stale_acks", {ack0, ack1}, 0);
        check("t3_stale_in_valid", iv, 0);
        check("t3_stale_rdata", rd0, 0);
        ov = 1'b0;
        tick();
        check("t3_idle", iv, 0);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h55; sel[0] = 4'h3; wd[0] = 32'hA5A5A5A5;
        tick();
        check("t3_m0_issue", iv, 1);
        check("t3_m0_addr", cad, 23'h55);
        check("t3_m0_grant", gid, 0);
        tick();
        check("t3_m0_ack", ack0, 1);
        req[0] = 1'b0;
        tick();
        check("t3_m0_ack_once", ack0, 0);

        // m0 keeps req through its ack cycle, drops one cycle late
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 23'h20;
        tick();
        check("t4_issue", iv, 1);
        tick();
        check("t4_ack", ack0, 1);
        tick();
        check("t4_no_reissue", iv, 0);
        check("t4_no_reack", ack0, 0);
        req[0] = 1'b0;
        tick();
        check("t4_no_reissue2", iv, 0);
        tick();
        check("t4_quiet", {iv, ack0, ack1}, 0);

        // both ports issuing back-to-back writes
        do_reset();
`ifdef SDRAM_ARB_RR_EN
        run_phase(0, 0, 4, 4, 0, 1);
        check("cont_count", wlog.size(), 8);
        if (wlog.size() >= 8)
            for (int i = 0; i < 8; i++) check("rr_order", wlog[i], i % 2);
`else
        run_phase(0, 0, 8, 1, 0, 1);
        check("cont_count", wlog.size(), 9);
        if (wlog.size() >= 9) begin
            for (int i = 0; i < 8; i++) check("fixed_order", wlog[i], 0);
            check("fixed_m1_after", wlog[8], 1);
        end
`endif

        // randomized mix of reads/writes, busy, latencies and spurious strobes
        run_phase(30, 3, 12, 12, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter sharing the single-command SDRAM controller between the Wishbone-side requester (port 0) and a DMA/accelerator requester (port 1). It grants one port at a time and forwards that port's address, direction, byte mask and write data to the controller's `in_valid`/`busy`/`out_valid` handshake. It returns read data and a one-cycle acknowledge to the granted port only. It sits between the user-project bus glue and the SDRAM controller, with at most one command outstanding.

## Interface
Parameters:
- `ADDR_W`, 23, controller word address width
- `DATA_W`, 32, data width

Ports:
- `wb_clk_i` in 1: sole clock, all state on rising edge
- `wb_rst_i` in 1: asynchronous, active-high reset
- `m0_req`, `m1_req` in 1: request; held high with stable fields until own ack
- `m0_we`, `m1_we` in 1: 1 = write, 0 = read
- `m0_addr`, `m1_addr` in ADDR_W: word address
- `m0_sel`, `m1_sel` in 4: byte mask, writes only
- `m0_wdata`, `m1_wdata` in DATA_W: write data
- `m0_ack`, `m1_ack` out 1: one-cycle completion pulse
- `m0_rdata`, `m1_rdata` out DATA_W: read data, valid while own ack = 1
- `ctrl_in_valid` out 1: command valid to controller
- `ctrl_rw` out 1: forwarded we
- `ctrl_addr` out ADDR_W, `ctrl_sel` out 4, `ctrl_wdata` out DATA_W: forwarded fields
- `ctrl_busy` in 1: controller cannot accept
- `ctrl_out_valid` in 1: one-cycle read-data strobe
- `ctrl_rdata` in DATA_W: read data
- `grant_id` out 1: currently/last granted port, for debug/LA

## Operation
- FSM states: IDLE, ISSUE, WAIT_RD, DONE. Registers: `state`, `gnt`, `last`, `rdata_q`.
- IDLE:
  - If no req, stay.
  - Else select a port per arbitration policy, latch it into `gnt`, set `last <= gnt`, go to ISSUE.
- ISSUE:
  - `ctrl_in_valid=1`; ctrl fields combinationally muxed from the granted port.
  - On an edge with `ctrl_busy=0`, the command is accepted.
  - Accepted write -> DONE. Accepted read -> WAIT_RD.
  - While `ctrl_busy=1`, hold ISSUE.
- WAIT_RD:
  - `ctrl_in_valid=0`.
  - On `ctrl_out_valid=1`, latch `ctrl_rdata` into `rdata_q` and go to DONE.
- DONE:
  - Granted port's ack = 1 for exactly this cycle; its rdata = `rdata_q`.
  - Requests are not sampled in DONE, which prevents re-granting a request the master is dropping. Next state is IDLE.
- Non-granted port: ack=0; rdata = `rdata_q` (don't-care).
- `ctrl_out_valid` outside WAIT_RD is ignored.
- A master that drops req before ack is a protocol violation. The arbiter completes the command anyway.
- Ctrl fields outside ISSUE: mux from `gnt`, `ctrl_in_valid=0`.
- Reset values:
  - `state` = IDLE, `gnt` = 0, `last` = 1 (port 0 first), `rdata_q` = 0.
  - All acks = 0, `ctrl_in_valid` = 0, `grant_id` = 0.
- Reset mid-operation: outputs drop immediately (asynchronous); an in-flight read's later `out_valid` lands in IDLE and is discarded.

## Timing
- Request seen at edge E0 (IDLE) -> ISSUE in cycle 1.
- Write, `busy=0`: accepted at E1, ack in cycle 2, IDLE in cycle 3. Total 3 cycles req-to-next-grant.
- Each busy cycle in ISSUE adds one cycle.
- Read: ack asserts the cycle after the `out_valid` cycle, with rdata stable that cycle.
- Both ports requesting at the same IDLE edge: resolved by policy; loser waits with req held.
- Minimum gap between consecutive grants: one IDLE cycle.

## Configuration
- `SDRAM_ARB_RR_EN` defined:
  - Round-robin. With both requesting, the port ≠ `last` wins. A single requester always wins.
- Undefined:
  - Fixed priority; port 0 wins whenever `m0_req=1`. Port 1 can starve.
  - `last` is still updated and `grant_id` still reported.

## Test plan
- Reset, then m0 write addr 0x000010, data 0xDEADBEEF, sel 0xF, `busy=0` -> `ctrl_in_valid` in cycle 1 with those fields; `m0_ack` in cycle 2 only; `m1_ack` never.
- m1 read addr 0x7FFFFF; model holds `busy=1` 3 cycles, then `out_valid` with 0x12345678 after 5 more -> `ctrl_in_valid` held 4 cycles, single `m1_ack` one cycle after `out_valid`, `m1_rdata=0x12345678`.
- Both ports request continuous writes, RR_EN defined -> grants alternate 0,1,0,1 over 8 transactions. RR_EN undefined -> all 8 to port 0, none to port 1 while m0_req held.
- Spurious `ctrl_out_valid` pulse during IDLE and during ISSUE of a write -> no ack generated; `rdata_q` unchanged.
- Assert `wb_rst_i` in WAIT_RD, release, then fire the stale `out_valid` -> acks stay 0, `ctrl_in_valid=0` during reset, state IDLE, next m0 request served normally.
- m0 holds req through its ack cycle (drops one cycle late) -> exactly one command issued for it; no duplicate `ctrl_in_valid`.
